serial_adder_ctrl: RTL and testbench

Bit-serial addition controller that time-shares a single one-bit `full_adder` instance to add two WIDTH-bit operands, one bit per clock, LSB first. It sits between a requesting datapath and the one-bit adder cell. It accepts an operation on a start strobe, sequences the operand bits and the carry chain through the cell, and returns a registered sum, carry-out and signed overflow with a done pulse.

---
 rtl/serial_adder_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add controller time-sharing one full_adder cell
//
// Adds two WIDTH-bit operands one bit per clock, LSB first, through a single
// combinational full_adder cell, and returns a registered sum, carry-out and
// signed overflow with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the 'sub' port, a-b mode).
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request strobe, accepted in IDLE or DONE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cin    in   carry-in, sampled on the accepting edge
//   sub    in   (SERIAL_ADDER_SUB_EN only) 1 = compute a-b
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse, results valid
//   sum    out  WIDTH-bit result, held until the next done
//   cout   out  carry out of the MSB
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  // Holds the WIDTH-1 sum bits already produced; the final bit comes straight
  // from the cell on the last cycle.
  logic [WIDTH-2:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_sum, fa_cout;
  logic               accept;
  logic               last_bit;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;
  logic [WIDTH-1:0]   sum_full;

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign accept   = start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign sum_full = {fa_sum, s_sh_q};

  // Subtraction is a + ~b + 1, so only the loaded operand and carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the state register only
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b_load;
      carry_d = c_load;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      s_sh_d  = sum_full[WIDTH-1:1];
      carry_d = fa_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        sum_d  = sum_full;
        cout_d = fa_cout;
        // carry_q is the carry into the MSB on the last cycle.
        ovf_d  = carry_q ^ fa_cout;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub_r = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    int ux, uy, sx, sy, ur, sr;
    logic o;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (s) begin
      ur = ux + (255 - uy) + 1;
      sr = sx - sy;
    end else begin
      ur = ux + uy + int'(c);
      sr = sx + sy + int'(c);
    end
    o = (sr > 127) || (sr < -128);
    return {o, ur[W], ur[W-1:0]};
  endfunction

  // Launch one operation at the current negedge and wait for done.
  // mid >= 0 pulses a stray start after that many RUN cycles.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input int mid, output int lat, output int nbusy,
                        output logic [W-1:0] rs, output logic rc, output logic ro,
                        output logic rd);
    a = ta; b = tb_v; cin = tc; sub_r = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_r = 1'b0;
    lat = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) nbusy++;
      start = (lat == mid);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    rs = sum; rc = cout; ro = ovf; rd = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++;
    if ({busy, done, cout, ovf, sum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
               busy, done, cout, ovf, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] va [3] = '{8'h3C, 8'hFF, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h05, 8'h01, 8'h01};
    logic         vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] es [3] = '{8'h41, 8'h01, 8'h80};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat, nb;
    logic [W-1:0] rs;
    logic rc, ro, rd;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, -1, lat, nb, rs, rc, ro, rd);
      total++;
      if (lat !== W || rd !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_latency got %0d done=%b want %0d", i, lat, rd, W);
      end
      total++;
      if (nb !== 0) begin
        bad++;
        $display("FAIL dir%0d_busy got %0d low cycles want 0", i, nb);
      end
      total++;
      if ({ro, rc, rs} !== {eo[i], ec[i], es[i]}) begin
        bad++;
        $display("FAIL dir%0d_result got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                 i, ro, rc, rs, eo[i], ec[i], es[i]);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== es[i]) begin
        bad++;
        $display("FAIL dir%0d_after got done=%b busy=%b sum=%h want 0 0 %h",
                 i, done, busy, sum, es[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    logic [W-1:0] rs;
    logic rc, ro, rd;
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, -1, lat, nb, rs, rc, ro, rd);
    total++;
    if (rs !== 8'h41 || rd !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got sum=%h done=%b want 41 1", rs, rd);
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, -1, lat, nb, rs, rc, ro, rd);
    total++;
    if (lat !== W || nb !== 0 || {ro, rc, rs} !== {2'b00, 8'h30}) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d nbusy=%0d ovf=%b cout=%b sum=%h want %0d 0 0 0 30",
               lat, nb, ro, rc, rs, W);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat, nb;
    logic [W-1:0] rs;
    logic rc, ro, rd;
    logic [W+1:0] exp;
    exp = model(8'h5A, 8'hC3, 1'b1, 1'b0);
    run_op(8'h5A, 8'hC3, 1'b1, 1'b0, 3, lat, nb, rs, rc, ro, rd);
    total++;
    if (lat !== W || {ro, rc, rs} !== exp) begin
      bad++;
      $display("FAIL midstart_result got lat=%0d {ovf,cout,sum}=%h want %0d %h",
               lat, {ro, rc, rs}, W, exp);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midstart_not_queued got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, nb;
    logic [W-1:0] rs;
    logic rc, ro, rd;
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, cout, ovf, sum} !== '0) begin
      bad++;
      $display("FAIL midrun_reset got busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
               busy, done, cout, ovf, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrun_idle got busy=%b done=%b want 0 0", busy, done);
    end
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, -1, lat, nb, rs, rc, ro, rd);
    total++;
    if (lat !== W || nb !== 0 || {ro, rc, rs} !== {2'b00, 8'h41}) begin
      bad++;
      $display("FAIL midrun_recover got lat=%0d nbusy=%0d {ovf,cout,sum}=%h want %0d 0 041",
               lat, nb, {ro, rc, rs}, W);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, nb;
    logic [W-1:0] rs, x, y;
    logic rc, ro, rd, c, s;
    logic [W+1:0] exp;
    for (int i = 0; i < 30; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      exp = model(x, y, c, s);
      run_op(x, y, c, s, -1, lat, nb, rs, rc, ro, rd);
      total++;
      if (lat !== W || nb !== 0 || {ro, rc, rs} !== exp) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got lat=%0d nbusy=%0d res=%h want %0d 0 %h",
                 i, x, y, c, s, lat, nb, {ro, rc, rs}, W, exp);
      end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] va [2] = '{8'h05, 8'h80};
    logic [W-1:0] vb [2] = '{8'h07, 8'h01};
    logic [W+1:0] ev [2] = '{{2'b00, 8'hFE}, {2'b11, 8'h7F}};
    int lat, nb;
    logic [W-1:0] rs;
    logic rc, ro, rd;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], 1'b0, 1'b1, -1, lat, nb, rs, rc, ro, rd);
      total++;
      if (lat !== W || {ro, rc, rs} !== ev[i]) begin
        bad++;
        $display("FAIL sub%0d got lat=%0d {ovf,cout,sum}=%h want %0d %h",
                 i, lat, {ro, rc, rs}, W, ev[i]);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_run();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
